// File: rtl/sha256_msg_padder_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder_if
//   Handshake bundle between a message-word source, the SHA-256 padder and
//   the downstream block/state registers.
//
//   Word side   : in_valid, in_ready, in_data[31:0], in_last, in_bytes[1:0]
//   Block side  : blk_valid, blk_ready, blk_data[511:0], blk_last
//
//   master : environment side (drives words, consumes blocks)
//   slave  : padder side (consumes words, drives blocks)
// ---------------------------------------------------------------------------
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
//   Front end of the SHA-256 datapath. Collects 32-bit big-endian message
//   words into a 512-bit block buffer, applies FIPS 180-4 padding (0x80
//   marker, zero fill, 64-bit message bit length in words 14/15) and hands
//   complete blocks downstream over a valid/ready handshake. One message at
//   a time; a start pulse opens a new message and aborts any in progress.
//
//   Parameters
//     LEN_W    width of the message bit counter (1..64), zero-extended into
//              the 64-bit length field; counter wraps modulo 2^LEN_W
//   Ports
//     CLK      clock, rising edge
//     RST      asynchronous active-low reset
//     start    1-cycle pulse: clear state, open a new message
//     bus      sha256_msg_padder_if.slave (word input, block output)
//     busy     high whenever the FSM is not IDLE
//     msg_bits live bit counter (only with SHA_PACK_LEN_OUT_EN defined)
//
//   Optional feature macro: SHA_PACK_LEN_OUT_EN
// ---------------------------------------------------------------------------
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  sha256_msg_padder_if.slave   bus,
  output logic                 busy
`ifdef SHA_PACK_LEN_OUT_EN
  ,
  output logic [LEN_W-1:0]     msg_bits
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, PAD, EMIT} state_t;

  state_t             state;
  logic [3:0]         widx;
  logic [LEN_W-1:0]   len;
  logic               marker_pend;
  logic               last_seen;
  logic [511:0]       blk_buf;
  logic               blk_valid_r;
  logic               blk_last_r;
  logic [63:0]        len64;
  logic [8:0]         woff;

  // Final word: keep the valid leading bytes, drop the marker right after
  // them, zero the rest. A full final word (nb==0) keeps all four bytes and
  // the marker is deferred to the next word.
  function automatic logic [31:0] pad_last_word(input logic [31:0] w,
                                                input logic [1:0]  nb);
    case (nb)
      2'd1:    return {w[31:24], 8'h80, 16'h0000};
      2'd2:    return {w[31:16], 8'h80, 8'h00};
      2'd3:    return {w[31:8],  8'h80};
      default: return w;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] word_bits(input logic       last,
                                                 input logic [1:0] nb);
    if (!last || nb == 2'd0) return LEN_W'(32);
    else                     return LEN_W'({nb, 3'b000});
  endfunction

  always_comb begin
    len64            = '0;
    len64[LEN_W-1:0] = len;
  end

  // Word i lives at bits [32*(15-i) +: 32]; 15-i is the bitwise inverse.
  assign woff          = {~widx, 5'b00000};

  assign bus.in_ready  = (state == FILL);
  assign bus.blk_valid = blk_valid_r;
  assign bus.blk_last  = blk_last_r;
  assign bus.blk_data  = blk_buf;
  assign busy          = (state != IDLE);
`ifdef SHA_PACK_LEN_OUT_EN
  assign msg_bits      = len;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      widx        <= '0;
      len         <= '0;
      marker_pend <= 1'b0;
      last_seen   <= 1'b0;
      blk_buf     <= '0;
      blk_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
    end else if (start) begin
      state       <= FILL;
      widx        <= '0;
      len         <= '0;
      marker_pend <= 1'b0;
      last_seen   <= 1'b0;
      blk_buf     <= '0;
      blk_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: ;

        FILL: begin
          if (bus.in_valid) begin
            len  <= len + word_bits(bus.in_last, bus.in_bytes);
            widx <= widx + 4'd1;
            if (bus.in_last) begin
              blk_buf[woff +: 32] <= pad_last_word(bus.in_data, bus.in_bytes);
              marker_pend         <= (bus.in_bytes == 2'd0);
              last_seen           <= 1'b1;
            end else begin
              blk_buf[woff +: 32] <= bus.in_data;
            end
            // Word 15 written: block is full whether or not this was the last
            // word; the length always needs a further block in that case.
            if (widx == 4'd15) begin
              blk_valid_r <= 1'b1;
              state       <= EMIT;
            end else if (bus.in_last) begin
              state <= PAD;
            end
          end
        end

        PAD: begin
          if (widx == 4'd14 && !marker_pend) begin
            blk_buf[63:0] <= len64;
            blk_valid_r   <= 1'b1;
            blk_last_r    <= 1'b1;
            state         <= EMIT;
          end else begin
            blk_buf[woff +: 32] <= marker_pend ? 32'h8000_0000 : 32'h0000_0000;
            marker_pend         <= 1'b0;
            widx                <= widx + 4'd1;
            if (widx == 4'd15) begin
              blk_valid_r <= 1'b1;
              state       <= EMIT;
            end
          end
        end

        EMIT: begin
          if (bus.blk_ready) begin
            blk_valid_r <= 1'b0;
            widx        <= '0;
            blk_buf     <= '0;
            if (blk_last_r) begin
              blk_last_r <= 1'b0;
              state      <= IDLE;
            end else if (last_seen) begin
              state <= PAD;
            end else begin
              state <= FILL;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
